// File: rtl/pio_out_arbiter.sv
// pio_out_arbiter
//   Round-robin arbiter sharing the single output PIO Avalon-MM slave
//   (s1, offset 0) between NREQ valid/ready requesters. Each accepted
//   request becomes one single-cycle Avalon write. A shadow copy of the
//   PIO data register is kept so software/hardware can see what the PIO
//   is driving.
//
//   Optional feature macro: PIO_ARB_RMW_EN
//     defined   : masked read-modify-write against shadow
//     undefined : full-word writes, req_mask ignored
//
// Ports
//   clk, reset_n     clock, async active-low reset
//   req_valid/ready  per-requester handshake (ready is combinational)
//   req_data         requester i value at [i*DW +: DW]
//   req_mask         requester i bit mask, same packing (RMW only)
//   avm_*            Avalon-MM master towards the PIO slave
//   shadow           value currently held in the PIO data register
//   busy             high during the write cycle
//   grant_idx        most recently granted requester
//
// FSM states
//   state | meaning
//   IDLE  | arbitrate; accept one valid requester
//   WRITE | drive the single-cycle PIO write, update shadow

module pio_out_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int IW   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ*DW-1:0] req_mask,
  output logic               avm_chipselect,
  output logic               avm_write_n,
  output logic [1:0]         avm_address,
  output logic [31:0]        avm_writedata,
  output logic [DW-1:0]      shadow,
  output logic               busy,
  output logic [IW-1:0]      grant_idx
);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] sel;
  logic          any_valid;
  logic [DW-1:0] sel_data;
  logic [DW-1:0] new_value;

  assign avm_address = 2'b00;

  // Search begins one past the last grant. Iterating from the far end
  // down lets the nearest valid requester be the last (winning) assignment.
  always_comb begin
    int idx;
    sel       = grant_idx;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(grant_idx) + k) % NREQ;
      if (req_valid[idx]) begin
        sel       = IW'(idx);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_q == IDLE) && any_valid && (sel == IW'(i));
    end
  end

  assign sel_data = req_data[int'(sel)*DW +: DW];

`ifdef PIO_ARB_RMW_EN
  logic [DW-1:0] sel_mask;
  assign sel_mask  = req_mask[int'(sel)*DW +: DW];
  // Shadow is refreshed at the end of WRITE, so the next IDLE already
  // merges against the freshly written value.
  assign new_value = (shadow & ~sel_mask) | (sel_data & sel_mask);
`else
  logic unused_mask;
  assign unused_mask = ^req_mask;
  assign new_value   = sel_data;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_idx      <= IW'(NREQ-1);
      shadow         <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      busy           <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            grant_idx      <= sel;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_writedata  <= {{(32-DW){1'b0}}, new_value};
            busy           <= 1'b1;
          end
        end
        WRITE: begin
          // PIO captures writedata on this same edge.
          shadow         <= avm_writedata[DW-1:0];
          avm_chipselect <= 1'b0;
          avm_write_n    <= 1'b1;
          busy           <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_out_arbiter.sv
module tb_pio_out_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int IW   = 2;

  logic               clk;
  logic               reset_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*DW-1:0] req_mask;
  logic               avm_chipselect;
  logic               avm_write_n;
  logic [1:0]         avm_address;
  logic [31:0]        avm_writedata;
  logic [DW-1:0]      shadow;
  logic               busy;
  logic [IW-1:0]      grant_idx;

  int checks = 0;
  int errors = 0;

  pio_out_arbiter #(.NREQ(NREQ), .DW(DW), .IW(IW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .req_mask       (req_mask),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_address    (avm_address),
    .avm_writedata  (avm_writedata),
    .shadow         (shadow),
    .busy           (busy),
    .grant_idx      (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE after the
  // shadow has been updated.
  task automatic do_write(input int idx, input logic [15:0] data, input logic [15:0] mask,
                          input logic [15:0] exp);
    req_data[idx*DW +: DW] = data;
    req_mask[idx*DW +: DW] = mask;
    req_valid[idx] = 1'b1;
    #1;
    chk("wr_ready", 32'(req_ready), 32'(1 << idx));
    @(negedge clk);
    chk("wr_strobe", 32'(avm_write_n), 32'd0);
    chk("wr_cs", 32'(avm_chipselect), 32'd1);
    chk("wr_data", avm_writedata, {16'h0, exp});
    chk("wr_addr", 32'(avm_address), 32'd0);
    chk("wr_busy", 32'(busy), 32'd1);
    chk("wr_grant", 32'(grant_idx), 32'(idx));
    chk("wr_noready", 32'(req_ready), 32'd0);
    req_valid[idx] = 1'b0;
    @(negedge clk);
    chk("wr_shadow", 32'(shadow), 32'(exp));
    chk("wr_idle", 32'(avm_write_n), 32'd1);
    chk("wr_busy0", 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [15:0] rr_data [NREQ];
  int          order [6];
  logic [15:0] rmw_exp;

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_mask  = '0;
    reset_n   = 1'b0;
    for (int i = 0; i < NREQ; i++) rr_data[i] = 16'h1111 * 16'(i + 1);
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0; order[5] = 3;

    @(negedge clk);
    apply_reset();

    // Reset state held for 10 cycles with no requests.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_wn", 32'(avm_write_n), 32'd1);
      chk("rst_cs", 32'(avm_chipselect), 32'd0);
      chk("rst_shadow", 32'(shadow), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    chk("rst_grant", 32'(grant_idx), 32'd3);
    chk("rst_wdata", avm_writedata, 32'd0);

    // Single request from requester 2.
    do_write(2, 16'hA5C3, 16'hFFFF, 16'hA5C3);

    // Round robin from reset: all four valid.
    apply_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = rr_data[i];
    req_mask  = '1;
    req_valid = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1 << order[g]));
      @(negedge clk);
      chk("rr_strobe", 32'(avm_write_n), 32'd0);
      chk("rr_data", avm_writedata, {16'h0, rr_data[order[g]]});
      chk("rr_grant", 32'(grant_idx), 32'(order[g]));
      chk("rr_noready", 32'(req_ready), 32'd0);
      req_valid[order[g]] = 1'b0;
      if (g == 3) begin
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
      end
      @(negedge clk);
      chk("rr_idle", 32'(avm_write_n), 32'd1);
      chk("rr_shadow", 32'(shadow), 32'(rr_data[order[g]]));
    end
    chk("rr_drained", 32'(req_ready), 32'd0);

    // Reset asserted during the strobe cycle.
    req_data[1*DW +: DW] = 16'hBEEF;
    req_valid = 4'b0010;
    #1;
    chk("mid_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    chk("mid_strobe", 32'(avm_write_n), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_wn", 32'(avm_write_n), 32'd1);
    chk("mid_cs", 32'(avm_chipselect), 32'd0);
    chk("mid_shadow", 32'(shadow), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_grant", 32'(grant_idx), 32'd3);
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    req_valid = 4'b0011;
    #1;
    chk("mid_next", 32'(req_ready), 32'b0001);
    @(negedge clk);
    chk("mid_next_data", avm_writedata, {16'h0, rr_data[0]});
    req_valid = '0;
    @(negedge clk);

    // Read-modify-write: shadow 0xFF00, data 0x00FF, mask 0x0F0F.
    do_write(0, 16'hFF00, 16'hFFFF, 16'hFF00);
`ifdef PIO_ARB_RMW_EN
    rmw_exp = 16'hF00F;
`else
    rmw_exp = 16'h00FF;
`endif
    do_write(1, 16'h00FF, 16'h0F0F, rmw_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
